// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - 640x480@60Hz VGA scanout of a 320x240 3-bit framebuffer
module vga_scanout #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int FB_WIDTH  = 320
) (
    input  logic        clk,
    input  logic        reset,
    output logic [16:0] mem_addr,
    input  logic [2:0]  mem_rdata,
    output logic        VGA_CLK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        frame_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS  = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_SS   = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] H_SE   = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS  = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_SS   = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] V_SE   = VW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic          tick;
    logic [HW-1:0] h_count;
    logic [VW-1:0] v_count;
    logic          visible;
    logic          hs_act;
    logic          vs_act;
    logic [16:0]   x17;
    logic [16:0]   y17;
    logic [16:0]   addr_next;

    // First pipeline stage: blank/sync wait here while the memory read is in flight
    logic          vis_s1;
    logic          hs_s1;
    logic          vs_s1;

    assign visible = (h_count < H_VIS) && (v_count < V_VIS);
    assign hs_act  = (h_count >= H_SS) && (h_count < H_SE);
    assign vs_act  = (v_count >= V_SS) && (v_count < V_SE);
    assign x17     = 17'(h_count >> 1);
    assign y17     = 17'(v_count >> 1);

    generate
        if (FB_WIDTH == 320) begin : g_shift
            assign addr_next = (y17 << 8) + (y17 << 6) + x17;
        end else begin : g_mul
            assign addr_next = y17 * 17'(FB_WIDTH) + x17;
        end
    endgenerate

    assign VGA_SYNC_N = 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick        <= 1'b0;
            VGA_CLK     <= 1'b0;
            h_count     <= '0;
            v_count     <= '0;
            mem_addr    <= 17'd0;
            vis_s1      <= 1'b0;
            hs_s1       <= 1'b1;
            vs_s1       <= 1'b1;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= 8'd0;
            VGA_G       <= 8'd0;
            VGA_B       <= 8'd0;
            frame_start <= 1'b0;
        end else begin
            tick        <= ~tick;
            VGA_CLK     <= tick;
            frame_start <= tick && (h_count == '0) && (v_count == '0);
            if (tick) begin
                if (h_count == H_LAST) begin
                    h_count <= '0;
                    v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
                end else begin
                    h_count <= h_count + 1'b1;
                end
                mem_addr    <= visible ? addr_next : 17'd0;
                vis_s1      <= visible;
                hs_s1       <= ~hs_act;
                vs_s1       <= ~vs_act;
                VGA_BLANK_N <= vis_s1;
                VGA_HS      <= hs_s1;
                VGA_VS      <= vs_s1;
                // Masking by the delayed visible flag keeps blanking-time read data off the pins
                VGA_R       <= vis_s1 ? {8{mem_rdata[2]}} : 8'd0;
                VGA_G       <= vis_s1 ? {8{mem_rdata[1]}} : 8'd0;
                VGA_B       <= vis_s1 ? {8{mem_rdata[0]}} : 8'd0;
            end
        end
    end
endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Read-side counterpart to the pixel-writer blocks that fill the 320x240, 3-bit colour framebuffer.
- Generates 640x480@60Hz VGA timing from the 50 MHz clock.
- Reads the framebuffer through a synchronous single-port read interface, doubling each stored pixel in x and y.
- Drives the DE-series VGA DAC pins with colour, syncs and blank all aligned to the same pixel.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
FB_WIDTH, 320, framebuffer width in stored pixels

Ports:
clk  input  1  50 MHz system clock
reset  input  1  asynchronous, active-low reset
mem_addr  output  17  framebuffer read address
mem_rdata  input  3  framebuffer read data {R,G,B}, valid 1 clk after mem_addr
VGA_CLK  output  1  25 MHz pixel clock to DAC
VGA_HS  output  1  horizontal sync, active low
VGA_VS  output  1  vertical sync, active low
VGA_BLANK_N  output  1  high only during visible pixels
VGA_SYNC_N  output  1  tied low
VGA_R  output  8  red
VGA_G  output  8  green
VGA_B  output  8  blue
frame_start  output  1  one-clk pulse at the start of each frame

Behaviour:
- One clock: clk, 50 MHz. Reset: asynchronous, active-low on `reset`.
- Reset values (asynchronous on reset low):
  - tick=0, VGA_CLK=0, h_count=0, v_count=0, mem_addr=0.
  - VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_R/G/B=0, VGA_SYNC_N=0, frame_start=0.
  - All pipeline stages are cleared to the blank/inactive-sync state.
- Pixel tick: the tick register toggles every clk, so a pixel is 2 clk. VGA_CLK = registered tick, so its 25 MHz rising edge falls mid-pixel.
- Counters advance on tick=1 cycles only:
  - h_count runs 0..799 (H total = sum of the H parameters), then wraps to 0.
  - v_count increments when h_count wraps and runs 0..524, then wraps to 0.
- frame_start is high for exactly one clk, on the tick cycle in which (h,v) wraps to (0,0).
- Address stage (tick T+1, registered):
  - Visible (h<640 and v<480): mem_addr = (v>>1)*FB_WIDTH + (h>>1). Implemented as (y<<8)+(y<<6)+x, 17-bit, no overflow; maximum 76799.
  - Outside the visible area, mem_addr holds 0.
- Data stage: mem_rdata is sampled on the following tick cycle. Memory latency is ≤1 clk, so the data is stable.
- Output stage (tick T+2):
  - VGA_R = {8{rdata[2]}}, VGA_G = {8{rdata[1]}}, VGA_B = {8{rdata[0]}} when visible, else all 0.
  - VGA_HS is low for h in [656,751].
  - VGA_VS is low for v in [490,491].
  - VGA_BLANK_N = visible.
  - Sync and blank are derived from the counters and delayed through a 2-stage shift register, so all pins change on the same clk for the same pixel.
- Pipeline latency: 2 pixel ticks (4 clk) from a counter value to its pins. A fixed offset, with the same offset for every pixel.
- Boundaries:
  - h=639→640: BLANK_N falls exactly when pixel 639 leaves the pipeline; RGB is forced 0 that cycle.
  - Line and frame wrap: no glitch pulse on HS/VS; the pipeline is continuous across the wrap.
  - Reset mid-frame: all outputs return to their reset values immediately. After release, timing restarts at (0,0) with the first tick 2 clk later; the first visible pixel reaches the pins 4 clk after that.
  - mem_rdata X during blanking is never propagated, because RGB is masked.

Test Plan:
1. Reset held 10 clk, then released → during reset HS=VS=1, BLANK_N=0, RGB=0, mem_addr=0; VGA_CLK toggles every clk after release.
2. Run one full line → period 1600 clk; HS low 192 clk, starting 1312 clk after BLANK_N rises; BLANK_N high 1280 clk per visible line.
3. Run 2 frames → frame_start pulses are exactly 840000 clk apart and each is 1 clk wide; VS low 3200 clk starting at line 490.
4. Address sequence → h=0,1 give addr 0; h=2 gives 1; h=639 gives 319; lines v=0 and v=1 both give 0..319; v=2 starts at 320; v=479, h=639 gives 76799; blanking holds 0.
5. Memory model returning addr[2:0] (1-clk latency) → pixel pair at addr 4 shows VGA_R=FF, G=00, B=00, coincident with BLANK_N=1; pixels in blanking show 0 even with mem_rdata=3'b111.
6. reset pulsed low at v=200, h=300 → outputs go to reset values in the same cycle; after release, the first frame_start occurs 2 clk later; addr 0 data appears on the pins with BLANK_N=1 at the specified latency.
